// File: rtl/switch_allocator.sv
// Switch allocator: per-output reservation arbitration with a held N x N crossbar.
// Optional macro SWITCH_ALLOC_ROUND_ROBIN_EN selects round-robin; fixed priority otherwise.
module switch_allocator #(
  parameter int N             = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int REQUEST_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N*DATA_WIDTH-1:0]    data_in,
  input  logic [N-1:0]               valid_in,
  output logic [N-1:0]               ready_in,
  output logic [N*DATA_WIDTH-1:0]    data_out,
  output logic [N-1:0]               valid_out,
  input  logic [N-1:0]               ready_out,
  input  logic [N-1:0]               routeReserveRequestValid,
  input  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest,
  input  logic [N-1:0]               routeRelieve,
  output logic [N-1:0]               routeReserveStatus
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]           busy_q, busy_d;
  logic [N-1:0]           granted_q, granted_d;
  logic [N-1:0][IDXW-1:0] owner_q, owner_d;
  logic [N-1:0][IDXW-1:0] route_q, route_d;
`ifdef SWITCH_ALLOC_ROUND_ROBIN_EN
  logic [N-1:0][IDXW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  always_comb begin
    logic        found;
    int unsigned idx;
`ifdef SWITCH_ALLOC_ROUND_ROBIN_EN
    int unsigned ptr;
`endif
    busy_d    = busy_q;
    granted_d = granted_q;
    owner_d   = owner_q;
    route_d   = route_q;
`ifdef SWITCH_ALLOC_ROUND_ROBIN_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    found     = 1'b0;
    idx       = 0;

    for (int unsigned i = 0; i < N; i++) begin
      if (routeRelieve[i] && granted_q[i]) begin
        granted_d[i]          = 1'b0;
        busy_d[route_q[i]]    = 1'b0;
      end
    end

    // Arbitration looks at busy_q, so an output freed this cycle waits one cycle.
    for (int unsigned o = 0; o < N; o++) begin
      found = 1'b0;
      if (!busy_q[o]) begin
        for (int unsigned k = 0; k < N; k++) begin
`ifdef SWITCH_ALLOC_ROUND_ROBIN_EN
          ptr = 32'(rr_ptr_q[o]);
          idx = (ptr + k) % N;
`else
          idx = k;
`endif
          if (!found && routeReserveRequestValid[idx] && !granted_q[idx] &&
              routeReserveRequest[idx*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(o)) begin
            found          = 1'b1;
            busy_d[o]      = 1'b1;
            owner_d[o]     = IDXW'(idx);
            granted_d[idx] = 1'b1;
            route_d[idx]   = IDXW'(o);
`ifdef SWITCH_ALLOC_ROUND_ROBIN_EN
            rr_ptr_d[o]    = IDXW'((idx + 1) % N);
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      granted_q <= '0;
      owner_q   <= '0;
      route_q   <= '0;
`ifdef SWITCH_ALLOC_ROUND_ROBIN_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      busy_q    <= busy_d;
      granted_q <= granted_d;
      owner_q   <= owner_d;
      route_q   <= route_d;
`ifdef SWITCH_ALLOC_ROUND_ROBIN_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  always_comb begin
    data_out  = '0;
    valid_out = '0;
    ready_in  = '0;
    for (int unsigned o = 0; o < N; o++) begin
      if (busy_q[o]) begin
        data_out[o*DATA_WIDTH +: DATA_WIDTH] = data_in[32'(owner_q[o])*DATA_WIDTH +: DATA_WIDTH];
        valid_out[o] = valid_in[owner_q[o]];
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      ready_in[i] = granted_q[i] & ready_out[route_q[i]];
    end
  end

  assign routeReserveStatus = granted_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator with a queue of expected values.
module tb_switch_allocator;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int RW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    valid_in;
  logic [N-1:0]    ready_in;
  logic [N*DW-1:0] data_out;
  logic [N-1:0]    valid_out;
  logic [N-1:0]    ready_out;
  logic [N-1:0]    req_v;
  logic [N*RW-1:0] req;
  logic [N-1:0]    relieve;
  logic [N-1:0]    status;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   win[4];

  switch_allocator #(.N(N), .DATA_WIDTH(DW), .REQUEST_WIDTH(RW)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .data_in                  (data_in),
    .valid_in                 (valid_in),
    .ready_in                 (ready_in),
    .data_out                 (data_out),
    .valid_out                (valid_out),
    .ready_out                (ready_out),
    .routeReserveRequestValid (req_v),
    .routeReserveRequest      (req),
    .routeRelieve             (relieve),
    .routeReserveStatus       (status)
  );

  always #5 clk = ~clk;

  task automatic expect_v(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: got %h required none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: got %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int o, input logic v);
    req[i*RW +: RW] = RW'(o);
    req_v[i]        = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef SWITCH_ALLOC_ROUND_ROBIN_EN
    win = '{0, 2, 0, 2};
`else
    win = '{0, 0, 0, 0};
`endif
    rst       = 1'b1;
    data_in   = 32'h44332211;
    valid_in  = 4'hF;
    ready_out = 4'hF;
    req_v     = '0;
    req       = '0;
    relieve   = '0;
    #3;
    expect_v("rst_status", 64'h0);      check(status);
    expect_v("rst_valid_out", 64'h0);   check(valid_out);
    expect_v("rst_data_out", 64'h0);    check(data_out);
    expect_v("rst_ready_in", 64'h0);    check(ready_in);
    step();
    rst = 1'b0;

    // single route 1 -> 3
    valid_in = 4'b0010;
    data_in  = 32'h4433A511;
    set_req(1, 3, 1'b1);
    #1;
    expect_v("t1_status_before_edge", 64'h0); check(status);
    expect_v("t1_status_granted", 64'h2);
    step();
    check(status);
    req_v = '0;
    expect_v("t1_valid_out", 64'h8);          check(valid_out);
    expect_v("t1_data_out", 64'hA5000000);    check(data_out);
    ready_out = 4'b0111;
    #1;
    expect_v("t1_ready_in_blocked", 64'h0);   check(ready_in);
    ready_out = 4'hF;
    #1;
    expect_v("t1_ready_in_open", 64'h2);      check(ready_in);
    relieve[1] = 1'b1;
    expect_v("t1_status_relieved", 64'h0);
    step();
    relieve = '0;
    check(status);
    expect_v("t1_valid_out_relieved", 64'h0); check(valid_out);

    // inputs 0 and 2 contend for output 1
    set_req(0, 1, 1'b1);
    set_req(2, 1, 1'b1);
    for (int r = 0; r < 4; r++) begin
      expect_v($sformatf("fair_grant_%0d", r), 64'd1 << win[r]);
      step();
      check(status);
      relieve         = '0;
      relieve[win[r]] = 1'b1;
      expect_v($sformatf("fair_gap_%0d", r), 64'h0);
      step();
      check(status);
      relieve = '0;
    end
    req_v = '0;

    // four disjoint routes in parallel
    set_req(0, 2, 1'b1);
    set_req(1, 3, 1'b1);
    set_req(2, 0, 1'b1);
    set_req(3, 1, 1'b1);
    data_in   = 32'h44332211;
    valid_in  = 4'hF;
    ready_out = 4'b0101;
    expect_v("par_status", 64'hF);
    step();
    check(status);
    req_v = '0;
    expect_v("par_data_out", 64'h22114433);   check(data_out);
    expect_v("par_valid_out", 64'hF);         check(valid_out);
    expect_v("par_ready_in", 64'h5);          check(ready_in);
    relieve = 4'hF;
    expect_v("par_released", 64'h0);
    step();
    relieve = '0;
    check(status);
    ready_out = 4'hF;

    // release latency and out-of-range request
    set_req(0, 2, 1'b1);
    expect_v("hold_status", 64'h1);
    step();
    check(status);
    req_v[0] = 1'b0;
    set_req(1, 2, 1'b1);
    set_req(3, 7, 1'b1);
    expect_v("hold_contend", 64'h1);
    step();
    check(status);
    expect_v("hold_valid_out", 64'h4);        check(valid_out);
    expect_v("hold_data_out", 64'h00110000);  check(data_out);
    relieve[0] = 1'b1;
    expect_v("hold_relieve_t1", 64'h0);
    step();
    relieve = '0;
    check(status);
    expect_v("hold_relieve_t2", 64'h2);
    step();
    check(status);
    expect_v("handoff_data_out", 64'h00220000); check(data_out);
    expect_v("handoff_valid_out", 64'h4);       check(valid_out);
    req_v[1] = 1'b0;
    expect_v("bad_index_never", 64'h2);
    step();
    check(status);

    // async reset with two routes held, then fresh arbitration
    set_req(2, 1, 1'b1);
    expect_v("pre_rst_status", 64'h6);
    step();
    check(status);
    expect_v("pre_rst_ready_in", 64'h6);      check(ready_in);
    expect_v("pre_rst_valid_out", 64'h6);     check(valid_out);
    req_v = '0;
    #2;
    rst = 1'b1;
    #1;
    expect_v("async_rst_status", 64'h0);      check(status);
    expect_v("async_rst_valid_out", 64'h0);   check(valid_out);
    expect_v("async_rst_ready_in", 64'h0);    check(ready_in);
    expect_v("async_rst_data_out", 64'h0);    check(data_out);
    rst = 1'b0;
    set_req(2, 1, 1'b1);
    set_req(3, 1, 1'b1);
    expect_v("post_rst_grant", 64'h4);
    step();
    check(status);
    req_v = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
